exp4_medidor_periodico: RTL and testbench
=========================================

Name: exp4_medidor_periodico

Overview:
- Sequencer that sits around the exp4_sensor ultrasonic measurement block and drives it autonomously.
- Issues periodic medir pulses and waits for pronto, with a timeout.
- Latches the 3-digit BCD medida (cm) into a stable output register and raises a proximity alarm against a BCD threshold.
- Feeds the sensor's medir input; consumes its medida/pronto outputs.

Parameters:
- MEDIR_CICLOS, 5: width of the medir pulse, in clock cycles.
- TIMEOUT_CICLOS, 2_500_000: maximum cycles spent in ESPERA (50 ms at 50 MHz).
- INTERVALO_CICLOS, 5_000_000: idle cycles between measurements (100 ms at 50 MHz).

Ports:
- clock  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low reset.
- ligar  in  1  level; 1 enables periodic measurement.
- pronto_sensor  in  1  end-of-measurement pulse from the sensor block.
- medida  in  12  BCD distance from the sensor (hundreds/tens/units).
- limiar  in  12  BCD alarm threshold.
- medir  out  1  measurement request to the sensor.
- medida_valida  out  12  last successfully captured BCD distance.
- nova_medida  out  1  one-cycle strobe: medida_valida updated.
- alarme  out  1  1 when last captured medida < limiar.
- erro_timeout  out  1  last attempt timed out.
- db_estado  out  4  current FSM state code.

Behaviour:
- Reset (reset=0, async): state INICIAL; all outputs 0; all counters 0.
- States, encoded for db_estado: INICIAL=0, DISPARA=1, ESPERA=2, ARMAZENA=3, FALHA=4, INTERVALO=5. Unused codes go to INICIAL.
- INICIAL: waits for ligar=1, then goes to DISPARA on the next edge.
- DISPARA:
  - medir=1 (Moore) for exactly MEDIR_CICLOS cycles, then ESPERA.
  - Timer cleared on entry to ESPERA.
- ESPERA:
  - Timer increments each cycle.
  - pronto_sensor=1: go to ARMAZENA; on that same edge, medida_valida<=medida and alarme<=(medida<limiar).
  - Timer reaches TIMEOUT_CICLOS-1 without pronto: go to FALHA.
  - pronto and timeout in the same cycle: pronto wins.
- ARMAZENA:
  - Lasts one cycle; nova_medida=1 only in this state.
  - erro_timeout cleared.
  - Next state is INTERVALO.
- FALHA:
  - Lasts one cycle; erro_timeout<=1.
  - medida_valida and alarme hold their previous values.
  - Next state is INTERVALO.
- INTERVALO: counts INTERVALO_CICLOS cycles, then goes to DISPARA if ligar=1, else INICIAL.
- ligar deasserted mid-measurement: the current cycle completes (capture or timeout); no new medir is issued.
- pronto_sensor outside ESPERA is ignored.
- Comparison: plain unsigned 12-bit compare. This is equal to numeric order for valid BCD. Invalid digits are not checked.
- Latency:
  - medir rises 1 cycle after ligar is sampled in INICIAL.
  - nova_medida is high the cycle after pronto_sensor is sampled.
- Counters are sized by $clog2 of the largest parameter and must not wrap within a state.

Optional Feature:
- Macro: EXP4_CONTA_FALHAS_EN.
- Enabled:
  - Extra output db_falhas[3:0] counts consecutive timeouts.
  - Increments on FALHA entry and saturates at 15.
  - Cleared on ARMAZENA entry and on reset.
- Disabled: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package exp4_pkg holds:
  - state encodings (INICIAL..INTERVALO);
  - default timing constants (50 MHz cycles for 50 ms and 100 ms);
  - BCD width constant (12).
- One sub-module: contador_m, a generic modulo-M counter with zera/conta inputs and fim output.
  - Instantiated for the DISPARA pulse, ESPERA timeout and INTERVALO wait.
  - FSM and datapath registers stay in the top.

Test Plan:
Bench parameters: MEDIR_CICLOS=5, TIMEOUT_CICLOS=500, INTERVALO_CICLOS=1000.
1. Reset pulled low for 10 cycles mid-simulation -> all outputs 0, db_estado=0, no medir while ligar=0.
2. ligar=1; pronto_sensor 100 cycles after medir falls, with medida=12'h100, limiar=12'h050 -> medir high exactly 5 cycles, nova_medida one-cycle pulse, medida_valida=12'h100, alarme=0, erro_timeout=0.
3. Next cycle: medida=12'h045, limiar=12'h050 -> medida_valida=12'h045, alarme=1; next medir rises 1000 cycles after ARMAZENA.
4. No pronto_sensor -> FALHA after 500 ESPERA cycles, erro_timeout=1, medida_valida still 12'h045. A subsequent good capture clears erro_timeout. With EXP4_CONTA_FALHAS_EN, three straight timeouts give db_falhas=3, then 0 after a capture.
5. pronto_sensor exactly on the final timeout cycle -> ARMAZENA taken, erro_timeout=0. ligar dropped during ESPERA -> capture completes, then INICIAL after INTERVALO, no further medir.
6. reset asserted during ESPERA -> immediate INICIAL, all outputs 0; after release with ligar=1, normal cycle restarts from DISPARA.

Source files
------------

// File: rtl/exp4_pkg.sv
// Shared constants for the exp4 periodic measurement sequencer: FSM state codes,
// default 50 MHz timing constants and the BCD distance width.
package exp4_pkg;

    localparam int BCD_W = 12;

    localparam int MEDIR_CICLOS_PADRAO     = 5;
    localparam int TIMEOUT_CICLOS_PADRAO   = 2_500_000;
    localparam int INTERVALO_CICLOS_PADRAO = 5_000_000;

    localparam logic [3:0] INICIAL   = 4'd0;
    localparam logic [3:0] DISPARA   = 4'd1;
    localparam logic [3:0] ESPERA    = 4'd2;
    localparam logic [3:0] ARMAZENA  = 4'd3;
    localparam logic [3:0] FALHA     = 4'd4;
    localparam logic [3:0] INTERVALO = 4'd5;

    // Packed BCD keeps digit weights in bit order, so a binary compare is a numeric compare.
    function automatic logic abaixo_limiar(input logic [BCD_W-1:0] med,
                                           input logic [BCD_W-1:0] lim);
        return med < lim;
    endfunction

endpackage

// File: rtl/exp4_medidor_periodico_contador_m.sv
// Generic modulo-M counter: zera clears, conta advances, fim flags the last count.
module contador_m #(
    parameter int M = 4,
    parameter int W = (M > 1) ? $clog2(M) : 1
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim
);

    logic [W-1:0] r_cont;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cont <= '0;
        end else if (zera) begin
            r_cont <= '0;
        end else if (conta) begin
            r_cont <= (r_cont == W'(M - 1)) ? '0 : r_cont + W'(1);
        end
    end

    assign fim = (r_cont == W'(M - 1));

endmodule

// File: rtl/exp4_medidor_periodico.sv
// Autonomous sequencer for the exp4_sensor block: periodic medir pulses, timeout,
// BCD capture and proximity alarm. Optional macro EXP4_CONTA_FALHAS_EN adds db_falhas.
module exp4_medidor_periodico
    import exp4_pkg::*;
#(
    parameter int MEDIR_CICLOS     = MEDIR_CICLOS_PADRAO,
    parameter int TIMEOUT_CICLOS   = TIMEOUT_CICLOS_PADRAO,
    parameter int INTERVALO_CICLOS = INTERVALO_CICLOS_PADRAO
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ligar,
    input  logic             pronto_sensor,
    input  logic [BCD_W-1:0] medida,
    input  logic [BCD_W-1:0] limiar,
    output logic             medir,
    output logic [BCD_W-1:0] medida_valida,
    output logic             nova_medida,
    output logic             alarme,
    output logic             erro_timeout,
    output logic [3:0]       db_estado
`ifdef EXP4_CONTA_FALHAS_EN
    ,
    output logic [3:0]       db_falhas
`endif
);

    localparam int MAIOR_AB = (MEDIR_CICLOS > TIMEOUT_CICLOS) ? MEDIR_CICLOS : TIMEOUT_CICLOS;
    localparam int MAIOR    = (MAIOR_AB > INTERVALO_CICLOS) ? MAIOR_AB : INTERVALO_CICLOS;
    localparam int CONT_W   = (MAIOR > 1) ? $clog2(MAIOR) : 1;

    logic [3:0]       r_estado;
    logic [3:0]       w_prox;
    logic             w_fim_disp;
    logic             w_fim_esp;
    logic             w_fim_int;
    logic             w_captura;
    logic             w_estouro;
    logic [BCD_W-1:0] r_medida_valida;
    logic             r_alarme;
    logic             r_erro_timeout;

    // Each timer is held clear outside its own state, so it restarts at 0 on entry.
    contador_m #(.M(MEDIR_CICLOS), .W(CONT_W)) u_cont_dispara (
        .clock (clock),
        .reset (reset),
        .zera  (r_estado != DISPARA),
        .conta (r_estado == DISPARA),
        .fim   (w_fim_disp)
    );

    contador_m #(.M(TIMEOUT_CICLOS), .W(CONT_W)) u_cont_espera (
        .clock (clock),
        .reset (reset),
        .zera  (r_estado != ESPERA),
        .conta (r_estado == ESPERA),
        .fim   (w_fim_esp)
    );

    contador_m #(.M(INTERVALO_CICLOS), .W(CONT_W)) u_cont_intervalo (
        .clock (clock),
        .reset (reset),
        .zera  (r_estado != INTERVALO),
        .conta (r_estado == INTERVALO),
        .fim   (w_fim_int)
    );

    // pronto has priority over the timeout when both land on the same cycle.
    assign w_captura = (r_estado == ESPERA) && pronto_sensor;
    assign w_estouro = (r_estado == ESPERA) && !pronto_sensor && w_fim_esp;

    always_comb begin
        w_prox = r_estado;
        case (r_estado)
            INICIAL:   if (ligar) w_prox = DISPARA;
            DISPARA:   if (w_fim_disp) w_prox = ESPERA;
            ESPERA: begin
                if (w_captura)      w_prox = ARMAZENA;
                else if (w_estouro) w_prox = FALHA;
            end
            ARMAZENA:  w_prox = INTERVALO;
            FALHA:     w_prox = INTERVALO;
            INTERVALO: if (w_fim_int) w_prox = ligar ? DISPARA : INICIAL;
            default:   w_prox = INICIAL;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado <= INICIAL;
        end else begin
            r_estado <= w_prox;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_medida_valida <= '0;
            r_alarme        <= 1'b0;
            r_erro_timeout  <= 1'b0;
        end else begin
            if (w_captura) begin
                r_medida_valida <= medida;
                r_alarme        <= abaixo_limiar(medida, limiar);
            end
            if (r_estado == ARMAZENA) r_erro_timeout <= 1'b0;
            if (r_estado == FALHA)    r_erro_timeout <= 1'b1;
        end
    end

`ifdef EXP4_CONTA_FALHAS_EN
    logic [3:0] r_falhas;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_falhas <= 4'd0;
        end else if (w_captura) begin
            r_falhas <= 4'd0;
        end else if (w_estouro && (r_falhas != 4'hF)) begin
            r_falhas <= r_falhas + 4'd1;
        end
    end

    assign db_falhas = r_falhas;
`else
    // Consecutive-timeout counter is not built in this configuration.
`endif

    assign medir         = (r_estado == DISPARA);
    assign nova_medida   = (r_estado == ARMAZENA);
    assign medida_valida = r_medida_valida;
    assign alarme        = r_alarme;
    assign erro_timeout  = r_erro_timeout;
    assign db_estado     = r_estado;

endmodule

// File: tb/tb_exp4_medidor_periodico.sv
// Directed bench for exp4_medidor_periodico with short timing parameters.
module tb_exp4_medidor_periodico;

    localparam int MED = 5;
    localparam int TMO = 500;
    localparam int INT = 1000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ligar = 1'b0;
    logic        pronto_sensor = 1'b0;
    logic [11:0] medida = '0;
    logic [11:0] limiar = '0;
    logic        medir;
    logic [11:0] medida_valida;
    logic        nova_medida;
    logic        alarme;
    logic        erro_timeout;
    logic [3:0]  db_estado;
`ifdef EXP4_CONTA_FALHAS_EN
    logic [3:0]  db_falhas;
`endif

    int checks = 0;
    int errors = 0;

    exp4_medidor_periodico #(
        .MEDIR_CICLOS     (MED),
        .TIMEOUT_CICLOS   (TMO),
        .INTERVALO_CICLOS (INT)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .ligar         (ligar),
        .pronto_sensor (pronto_sensor),
        .medida        (medida),
        .limiar        (limiar),
        .medir         (medir),
        .medida_valida (medida_valida),
        .nova_medida   (nova_medida),
        .alarme        (alarme),
        .erro_timeout  (erro_timeout),
        .db_estado     (db_estado)
`ifdef EXP4_CONTA_FALHAS_EN
        ,
        .db_falhas     (db_falhas)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [11:0] med;
        logic [11:0] lim;
        int          atraso;
        logic [11:0] exp_v;
        logic        exp_a;
    } vec_t;

    vec_t tab[6];

    task automatic step();
        @(negedge clock);
    endtask

    task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        checks++;
        if (atual !== esperado) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nome, atual, esperado);
        end
    endtask

    task automatic chk_zerado(input string tag);
        chk({tag, " db_estado"}, db_estado, 0);
        chk({tag, " medir"}, medir, 0);
        chk({tag, " medida_valida"}, medida_valida, 0);
        chk({tag, " nova_medida"}, nova_medida, 0);
        chk({tag, " alarme"}, alarme, 0);
        chk({tag, " erro_timeout"}, erro_timeout, 0);
    endtask

    // Waits (bounded) for medir, checks the wait and the pulse width; ends in ESPERA.
    task automatic pulso_medir(input int esp_n, input string tag);
        int n;
        int w;
        n = 0;
        while (medir !== 1'b1 && n < 3000) begin
            step();
            n++;
        end
        chk({tag, " ciclos ate medir"}, n, esp_n);
        w = 0;
        while (medir === 1'b1 && w < 50) begin
            step();
            w++;
        end
        chk({tag, " largura medir"}, w, MED);
        chk({tag, " estado ESPERA"}, db_estado, 2);
    endtask

    task automatic captura(input logic [11:0] med, input logic [11:0] lim, input int atraso,
                           input logic [11:0] exp_v, input logic exp_a, input string tag);
        repeat (atraso) step();
        medida        = med;
        limiar        = lim;
        pronto_sensor = 1'b1;
        step();
        pronto_sensor = 1'b0;
        chk({tag, " nova_medida alta"}, nova_medida, 1);
        chk({tag, " estado ARMAZENA"}, db_estado, 3);
        chk({tag, " medida_valida"}, medida_valida, exp_v);
        chk({tag, " alarme"}, alarme, exp_a);
        step();
        chk({tag, " nova_medida baixa"}, nova_medida, 0);
        chk({tag, " estado INTERVALO"}, db_estado, 5);
        chk({tag, " erro_timeout"}, erro_timeout, 0);
    endtask

    task automatic estouro(input logic [11:0] exp_v, input string tag);
        repeat (TMO - 1) step();
        chk({tag, " ainda ESPERA"}, db_estado, 2);
        step();
        chk({tag, " estado FALHA"}, db_estado, 4);
        chk({tag, " sem nova_medida"}, nova_medida, 0);
        step();
        chk({tag, " estado INTERVALO"}, db_estado, 5);
        chk({tag, " erro_timeout"}, erro_timeout, 1);
        chk({tag, " medida_valida mantida"}, medida_valida, exp_v);
    endtask

    initial begin
        int n;

        tab[0] = '{12'h100, 12'h050, 100, 12'h100, 1'b0};
        tab[1] = '{12'h049, 12'h050,   7, 12'h049, 1'b1};
        tab[2] = '{12'h050, 12'h050,  50, 12'h050, 1'b0};
        tab[3] = '{12'h999, 12'h000,   0, 12'h999, 1'b0};
        tab[4] = '{12'h000, 12'h001,   3, 12'h000, 1'b1};
        tab[5] = '{12'h045, 12'h050, 100, 12'h045, 1'b1};

        // Power-up reset, then idle with ligar=0 (stray pronto ignored).
        step();
        chk_zerado("reset inicial");
        repeat (3) step();
        reset = 1'b1;
        pronto_sensor = 1'b1;
        medida = 12'h321;
        step();
        pronto_sensor = 1'b0;
        n = 0;
        repeat (20) begin
            step();
            if (medir === 1'b1) n++;
        end
        chk("ocioso sem medir", n, 0);
        chk_zerado("ocioso");
        reset = 1'b0;
        repeat (10) step();
        chk_zerado("reset 10 ciclos");
        reset = 1'b1;
        step();

        // Table-driven captures with ligar held high.
        ligar = 1'b1;
        for (int i = 0; i < 6; i++) begin
            pulso_medir((i == 0) ? 1 : INT, $sformatf("vec%0d", i));
            captura(tab[i].med, tab[i].lim, tab[i].atraso, tab[i].exp_v, tab[i].exp_a,
                    $sformatf("vec%0d", i));
        end

        // pronto during INTERVALO is ignored.
        medida = 12'h777;
        limiar = 12'h999;
        pronto_sensor = 1'b1;
        step();
        pronto_sensor = 1'b0;
        chk("pronto fora ESPERA valida", medida_valida, 12'h045);
        chk("pronto fora ESPERA estado", db_estado, 5);
        chk("pronto fora ESPERA nova", nova_medida, 0);

        // Three consecutive timeouts.
        pulso_medir(INT - 1, "tmo1");
        estouro(12'h045, "tmo1");
        pulso_medir(INT, "tmo2");
        estouro(12'h045, "tmo2");
        pulso_medir(INT, "tmo3");
        estouro(12'h045, "tmo3");
`ifdef EXP4_CONTA_FALHAS_EN
        chk("db_falhas apos 3", db_falhas, 3);
`endif

        // pronto on the last ESPERA cycle wins over the timeout.
        pulso_medir(INT, "limite");
        captura(12'h123, 12'h200, TMO - 1, 12'h123, 1'b1, "limite");
`ifdef EXP4_CONTA_FALHAS_EN
        chk("db_falhas zerado", db_falhas, 0);
`endif

        // ligar dropped mid-ESPERA: capture completes, then back to INICIAL.
        pulso_medir(INT, "desliga");
        repeat (10) step();
        ligar = 1'b0;
        captura(12'h200, 12'h100, 10, 12'h200, 1'b0, "desliga");
        repeat (INT) step();
        chk("desliga estado INICIAL", db_estado, 0);
        n = 0;
        repeat (50) begin
            step();
            if (medir === 1'b1) n++;
        end
        chk("desliga sem medir", n, 0);
        chk("desliga valida mantida", medida_valida, 12'h200);

        // Asynchronous reset during ESPERA, then restart.
        ligar = 1'b1;
        pulso_medir(1, "rst");
        repeat (10) step();
        reset = 1'b0;
        #1;
        chk_zerado("reset em ESPERA");
        repeat (3) step();
        reset = 1'b1;
        pulso_medir(1, "pos reset");
        captura(12'h300, 12'h301, 5, 12'h300, 1'b1, "pos reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
